// File: rtl/viterbi_acs_scheduler.sv
// Viterbi K=3 rate-1/2 (7/5) ACS scheduler: feeds the four new states
// of each symbol through one shared ACS unit and keeps the metric bank.
// Ports: clock, reset (async, active-high); sym_valid/sym_in/sym_ready;
// acs_pm_ina/inb, HD_ina/inb, aen to the ACS; acs_pm_survivor/acs_label
// back; dec_valid/dec_ready/dec_bits/dec_best decision word; busy.
// Macro DEC_FIFO_EN: 4-entry decision FIFO with dec_ready backpressure.
module viterbi_acs_scheduler #(
  parameter logic [3:0] PM_INIT = 4'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym_in,
  output logic       sym_ready,
  output logic [3:0] acs_pm_ina,
  output logic [3:0] acs_pm_inb,
  output logic [1:0] HD_ina,
  output logic [1:0] HD_inb,
  output logic       aen,
  input  logic [3:0] acs_pm_survivor,
  input  logic       acs_label,
  output logic       dec_valid,
  input  logic       dec_ready,
  output logic [3:0] dec_bits,
  output logic [1:0] dec_best,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, DRAIN
  } state_t;

  state_t     state;
  logic [1:0] sym_q;
  logic [3:0] bank [4];
  logic [3:0] npm [3];
  logic [2:0] lab;

  logic       accept;
  logic       issue_go;
  logic [1:0] issue_idx;
  logic [1:0] issue_sym;
  logic [3:0] fin [4];
  logic [3:0] fmin;
  logic [1:0] fbest;
  logic [3:0] commit_bits;

  // Branch distance into new state n from pred {n0,b}; u = n1.
  function automatic logic [1:0] branch_hd(
    input logic [1:0] sym,
    input logic [1:0] n,
    input logic       b
  );
    logic [1:0] d;
    d = sym ^ {n[1] ^ n[0] ^ b, n[1] ^ b};
    return {1'b0, d[1]} + {1'b0, d[0]};
  endfunction

`ifdef DEC_FIFO_EN
  logic [5:0] fifo [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push;
  logic       pop;

  assign sym_ready = (state == IDLE) && (count != 3'd4);
`else
  logic dec_ready_unused;

  assign dec_ready_unused = dec_ready;
  assign sym_ready = (state == IDLE);
`endif

  assign accept = sym_valid && sym_ready;

  // Which new state the next cycle presents to the ACS.
  always_comb begin
    issue_go  = 1'b0;
    issue_idx = 2'd0;
    issue_sym = sym_q;
    unique case (state)
      IDLE: begin
        issue_go  = accept;
        issue_sym = sym_in;
      end
      ISSUE0: begin
        issue_go  = 1'b1;
        issue_idx = 2'd1;
      end
      ISSUE1: begin
        issue_go  = 1'b1;
        issue_idx = 2'd2;
      end
      ISSUE2: begin
        issue_go  = 1'b1;
        issue_idx = 2'd3;
      end
      default: ;
    endcase
  end

  // State 3's survivor arrives during DRAIN and is used directly.
  always_comb begin
    fin[0] = npm[0];
    fin[1] = npm[1];
    fin[2] = npm[2];
    fin[3] = acs_pm_survivor;
    fmin   = fin[0];
    fbest  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (fin[i] < fmin) begin
        fmin  = fin[i];
        fbest = 2'(i);
      end
    end
    commit_bits = {acs_label, lab};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sym_q      <= 2'd0;
      bank[0]    <= 4'd0;
      bank[1]    <= PM_INIT;
      bank[2]    <= PM_INIT;
      bank[3]    <= PM_INIT;
      npm[0]     <= 4'd0;
      npm[1]     <= 4'd0;
      npm[2]     <= 4'd0;
      lab        <= 3'd0;
      acs_pm_ina <= 4'd0;
      acs_pm_inb <= 4'd0;
      HD_ina     <= 2'd0;
      HD_inb     <= 2'd0;
      aen        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (issue_go) begin
        acs_pm_ina <= bank[{issue_idx[0], 1'b0}];
        acs_pm_inb <= bank[{issue_idx[0], 1'b1}];
        HD_ina     <= branch_hd(issue_sym, issue_idx, 1'b0);
        HD_inb     <= branch_hd(issue_sym, issue_idx, 1'b1);
        aen        <= 1'b1;
      end else begin
        acs_pm_ina <= 4'd0;
        acs_pm_inb <= 4'd0;
        HD_ina     <= 2'd0;
        HD_inb     <= 2'd0;
        aen        <= (state == ISSUE3);
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            sym_q <= sym_in;
            state <= ISSUE0;
            busy  <= 1'b1;
          end
        end
        ISSUE0: state <= ISSUE1;
        ISSUE1: begin
          npm[0] <= acs_pm_survivor;
          lab[0] <= acs_label;
          state  <= ISSUE2;
        end
        ISSUE2: begin
          npm[1] <= acs_pm_survivor;
          lab[1] <= acs_label;
          state  <= ISSUE3;
        end
        ISSUE3: begin
          npm[2] <= acs_pm_survivor;
          lab[2] <= acs_label;
          state  <= DRAIN;
        end
        DRAIN: begin
          for (int i = 0; i < 4; i++) begin
            bank[i] <= fin[i] - fmin;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEC_FIFO_EN
  assign push      = (state == DRAIN);
  assign pop       = dec_valid && dec_ready;
  assign dec_valid = (count != 3'd0);
  assign dec_bits  = fifo[rd_ptr][5:2];
  assign dec_best  = fifo[rd_ptr][1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo[i] <= 6'd0;
      end
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= {commit_bits, fbest};
        wr_ptr       <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_bits  <= 4'd0;
      dec_best  <= 2'd0;
    end else begin
      dec_valid <= (state == DRAIN);
      if (state == DRAIN) begin
        dec_bits <= commit_bits;
        dec_best <= fbest;
      end
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_acs_scheduler.sv
// Self-checking bench for viterbi_acs_scheduler with a behavioural
// trellis model and a registered model of the external ACS unit.
module tb_viterbi_acs_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sym_valid = 1'b0;
  logic [1:0] sym_in = 2'd0;
  logic       sym_ready;
  logic [3:0] acs_pm_ina, acs_pm_inb;
  logic [1:0] HD_ina, HD_inb;
  logic       aen;
  logic [3:0] acs_pm_survivor = 4'd0;
  logic       acs_label = 1'b0;
  logic       dec_valid;
  logic       dec_ready = 1'b1;
  logic [3:0] dec_bits;
  logic [1:0] dec_best;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int mbank [4];
  logic [3:0] obs_ina [4];
  logic [3:0] obs_inb [4];
  logic [1:0] obs_hda [4];
  logic [1:0] obs_hdb [4];
  logic [3:0] obs_bits;
  logic [1:0] obs_best;

  viterbi_acs_scheduler #(.PM_INIT(4'd4)) dut (
    .clock(clock),
    .reset(reset),
    .sym_valid(sym_valid),
    .sym_in(sym_in),
    .sym_ready(sym_ready),
    .acs_pm_ina(acs_pm_ina),
    .acs_pm_inb(acs_pm_inb),
    .HD_ina(HD_ina),
    .HD_inb(HD_inb),
    .aen(aen),
    .acs_pm_survivor(acs_pm_survivor),
    .acs_label(acs_label),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_bits(dec_bits),
    .dec_best(dec_best),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // External ACS unit: one-cycle latency, path a wins ties.
  always @(posedge clock) begin
    if (aen) begin
      if (int'(acs_pm_inb) + int'(HD_inb) <
          int'(acs_pm_ina) + int'(HD_ina)) begin
        acs_pm_survivor <= acs_pm_inb + 4'(HD_inb);
        acs_label       <= 1'b1;
      end else begin
        acs_pm_survivor <= acs_pm_ina + 4'(HD_ina);
        acs_label       <= 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int popc2(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  // Encoder output {c0,c1} leaving state p on input u.
  function automatic logic [1:0] enc_out(input int p, input int u);
    logic uu, s1, s0;
    uu = u[0];
    s1 = 1'((p >> 1) & 1);
    s0 = 1'(p & 1);
    return {uu ^ s1 ^ s0, uu ^ s0};
  endfunction

  function automatic int next_state(input int p, input int u);
    return 2 * u + ((p >> 1) & 1);
  endfunction

  function automatic void model_issue(
    input int n, input logic [1:0] sym,
    output int pa, output int pb, output int ha, output int hb
  );
    pa = 0; pb = 0; ha = 0; hb = 0;
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        if (next_state(p, u) == n) begin
          if (p % 2 == 0) begin
            pa = mbank[p];
            ha = popc2(sym ^ enc_out(p, u));
          end else begin
            pb = mbank[p];
            hb = popc2(sym ^ enc_out(p, u));
          end
        end
      end
    end
  endfunction

  function automatic void model_step(
    input logic [1:0] sym,
    output logic [3:0] bits, output logic [1:0] best
  );
    int npm [4];
    int mn, bi, nn, c;
    bits = 4'd0;
    for (int n = 0; n < 4; n++) npm[n] = 1000;
    for (int p = 0; p < 4; p++) begin
      for (int u = 0; u < 2; u++) begin
        nn = next_state(p, u);
        c = mbank[p] + popc2(sym ^ enc_out(p, u));
        if (c < npm[nn]) begin
          npm[nn] = c;
          bits[nn] = 1'(p & 1);
        end
      end
    end
    mn = npm[0];
    bi = 0;
    for (int n = 1; n < 4; n++) begin
      if (npm[n] < mn) begin
        mn = npm[n];
        bi = n;
      end
    end
    for (int n = 0; n < 4; n++) mbank[n] = npm[n] - mn;
    best = 2'(bi);
  endfunction

  task automatic apply_reset;
    @(negedge clock);
    reset = 1'b1;
    sym_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mbank[0] = 0;
    mbank[1] = 4;
    mbank[2] = 4;
    mbank[3] = 4;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // following idle cycle so calls chain back to back.
  task automatic run_sym(input logic [1:0] sym, input bit noise);
    int pa [4], pb [4], ha [4], hb [4];
    logic [3:0] eb;
    logic [1:0] ebest;
    for (int n = 0; n < 4; n++) begin
      model_issue(n, sym, pa[n], pb[n], ha[n], hb[n]);
    end
    model_step(sym, eb, ebest);
    checks++;
    if (sym_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_at_start: got %b want 1", sym_ready);
    end
    sym_valid = 1'b1;
    sym_in = sym;
    @(posedge clock);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k <= 5 && noise) begin
        sym_valid = 1'($urandom_range(0, 1));
        sym_in = 2'($urandom_range(0, 3));
      end else begin
        sym_valid = 1'b0;
      end
      if (k <= 4) begin
        obs_ina[k-1] = acs_pm_ina;
        obs_inb[k-1] = acs_pm_inb;
        obs_hda[k-1] = HD_ina;
        obs_hdb[k-1] = HD_inb;
        checks++;
        if ({aen, acs_pm_ina, acs_pm_inb, HD_ina, HD_inb} !==
            {1'b1, 4'(pa[k-1]), 4'(pb[k-1]), 2'(ha[k-1]), 2'(hb[k-1])}) begin
          failures++;
          $display("FAIL issue%0d: got aen=%b a=%0d/%0d b=%0d/%0d want 1 a=%0d/%0d b=%0d/%0d",
                   k - 1, aen, acs_pm_ina, HD_ina, acs_pm_inb, HD_inb,
                   pa[k-1], ha[k-1], pb[k-1], hb[k-1]);
        end
        checks++;
        if (acs_pm_ina > 4'd8 || acs_pm_inb > 4'd8) begin
          failures++;
          $display("FAIL bank_range: got %0d,%0d want <=8", acs_pm_ina, acs_pm_inb);
        end
      end
      if (k == 5) begin
        checks++;
        if (aen !== 1'b1) begin
          failures++;
          $display("FAIL drain_aen: got %b want 1", aen);
        end
      end
      checks++;
      if (busy !== (k <= 5)) begin
        failures++;
        $display("FAIL busy_k%0d: got %b want %b", k, busy, k <= 5);
      end
      checks++;
      if (dec_valid !== (k == 6)) begin
        failures++;
        $display("FAIL dec_valid_k%0d: got %b want %b", k, dec_valid, k == 6);
      end
      if (k == 6) begin
        obs_bits = dec_bits;
        obs_best = dec_best;
        checks++;
        if ({dec_bits, dec_best, aen} !== {eb, ebest, 1'b0}) begin
          failures++;
          $display("FAIL decision: got bits=%b best=%0d aen=%b want bits=%b best=%0d aen=0",
                   dec_bits, dec_best, aen, eb, ebest);
        end
      end
    end
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({sym_ready, aen, busy, dec_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 1000", {sym_ready, aen, busy, dec_valid});
    end
    checks++;
    if ({acs_pm_ina, acs_pm_inb, HD_ina, HD_inb} !== 12'd0) begin
      failures++;
      $display("FAIL reset_acs_in: got %h want 000", {acs_pm_ina, acs_pm_inb, HD_ina, HD_inb});
    end
    checks++;
    if ({dec_bits, dec_best} !== 6'd0) begin
      failures++;
      $display("FAIL reset_dec: got %h want 00", {dec_bits, dec_best});
    end
  endtask

  task automatic test_first_symbol;
    apply_reset();
    run_sym(2'b00, 1'b0);
    checks++;
    if ({obs_ina[1], obs_hda[1], obs_inb[1], obs_hdb[1]} !==
        {4'd4, 2'd1, 4'd4, 2'd1}) begin
      failures++;
      $display("FAIL first_issue1: got %0d/%0d %0d/%0d want 4/1 4/1",
               obs_ina[1], obs_hda[1], obs_inb[1], obs_hdb[1]);
    end
    checks++;
    if ({obs_bits, obs_best} !== 6'd0) begin
      failures++;
      $display("FAIL first_decision: got %b/%0d want 0000/0", obs_bits, obs_best);
    end
    run_sym(2'b00, 1'b0);
    checks++;
    if ({obs_ina[0], obs_inb[0], obs_ina[1], obs_inb[1]} !==
        {4'd0, 4'd5, 4'd2, 4'd5}) begin
      failures++;
      $display("FAIL first_bank: got %0d %0d %0d %0d want 0 5 2 5",
               obs_ina[0], obs_inb[0], obs_ina[1], obs_inb[1]);
    end
  endtask

  task automatic test_encoded_stream;
    logic [1:0] syms [5];
    logic [1:0] want [5];
    syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01};
    want = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_sym(syms[i], 1'b0);
      checks++;
      if (obs_best !== want[i]) begin
        failures++;
        $display("FAIL stream_best%0d: got %0d want %0d", i, obs_best, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    apply_reset();
    sym_valid = 1'b1;
    sym_in = 2'($urandom_range(0, 3));
    @(posedge clock);
    @(negedge clock);
    sym_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, sym_ready, aen} !== 3'b010) begin
      failures++;
      $display("FAIL mid_reset_state: got %b want 010", {busy, sym_ready, aen});
    end
    @(negedge clock);
    reset = 1'b0;
    mbank[0] = 0;
    mbank[1] = 4;
    mbank[2] = 4;
    mbank[3] = 4;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (dec_valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_reset_quiet: got %0d active cycles want 0", seen);
    end
    run_sym(2'($urandom_range(0, 3)), 1'b0);
  endtask

`ifdef DEC_FIFO_EN
  task automatic test_fifo;
    logic [5:0] q [$];
    logic [3:0] eb;
    logic [1:0] ebest;
    logic [1:0] s;
    logic [5:0] head;
    apply_reset();
    dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 2'($urandom_range(0, 3));
      model_step(s, eb, ebest);
      q.push_back({eb, ebest});
      sym_valid = 1'b1;
      sym_in = s;
      @(posedge clock);
      @(negedge clock);
      sym_valid = 1'b0;
      repeat (5) @(negedge clock);
    end
    checks++;
    if ({dec_valid, sym_ready, dec_bits, dec_best} !== {2'b10, q[0]}) begin
      failures++;
      $display("FAIL fifo_full: got v=%b r=%b head=%h want v=1 r=0 head=%h",
               dec_valid, sym_ready, {dec_bits, dec_best}, q[0]);
    end
    s = 2'($urandom_range(0, 3));
    sym_valid = 1'b1;
    sym_in = s;
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL fifo_block: got busy=%b want 0", busy);
    end
    dec_ready = 1'b1;
    @(negedge clock);
    dec_ready = 1'b0;
    void'(q.pop_front());
    checks++;
    if ({sym_ready, dec_bits, dec_best} !== {1'b1, q[0]}) begin
      failures++;
      $display("FAIL fifo_pop: got r=%b head=%h want r=1 head=%h",
               sym_ready, {dec_bits, dec_best}, q[0]);
    end
    model_step(s, eb, ebest);
    q.push_back({eb, ebest});
    @(negedge clock);
    sym_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL fifo_fifth: got busy=%b want 1", busy);
    end
    repeat (5) @(negedge clock);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      head = q.pop_front();
      checks++;
      if ({dec_valid, dec_bits, dec_best} !== {1'b1, head}) begin
        failures++;
        $display("FAIL fifo_drain%0d: got v=%b head=%h want v=1 head=%h",
                 i, dec_valid, {dec_bits, dec_best}, head);
      end
      @(negedge clock);
    end
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL fifo_empty: got %b want 0", dec_valid);
    end
  endtask
`endif

  task automatic test_back_to_back;
    apply_reset();
    for (int i = 0; i < 1000; i++) begin
      run_sym(2'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_first_symbol();
    test_encoded_stream();
    test_reset_mid();
`ifdef DEC_FIFO_EN
    test_fifo();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
